// File: rtl/mdu_if.sv
// Handshake bundle between the EX stage and the multiply/divide unit.
// The pipeline side issues operations; the MDU side reports busy and the HI/LO registers.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, A, B,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Runs on operand magnitudes and applies the result signs in a single fix-up cycle.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, CALC, FIX} MduState;

    MduState            state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic               isDiv;
    logic               negLo;
    logic               negHi;
    logic               divZero;
    logic               busyReg;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;

    logic               signedOp;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aAbs;
    logic [WIDTH-1:0]   bAbs;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divTrial;
    logic [2*WIDTH-1:0] prodFixed;
    logic [WIDTH-1:0]   quotFixed;
    logic [WIDTH-1:0]   remFixed;

    // Operand magnitudes; |0x80000000| stays 0x80000000 when read as unsigned.
    always_comb begin
        signedOp = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        aNeg     = signedOp & bus.A[WIDTH-1];
        bNeg     = signedOp & bus.B[WIDTH-1];
        aAbs     = aNeg ? (~bus.A + 1'b1) : bus.A;
        bAbs     = bNeg ? (~bus.B + 1'b1) : bus.B;
    end

    // Multiply keeps the partial product in the upper half and the unconsumed
    // multiplier bits in the lower half; divide keeps remainder above quotient.
    always_comb begin
        mulSum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, aMag};
        divTrial  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, bMag};
        prodFixed = negLo ? (~acc + 1'b1) : acc;
        quotFixed = negLo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        remFixed  = negHi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            aMag    <= '0;
            bMag    <= '0;
            isDiv   <= 1'b0;
            negLo   <= 1'b0;
            negHi   <= 1'b0;
            divZero <= 1'b0;
            busyReg <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                aMag    <= aAbs;
                                bMag    <= bAbs;
                                acc     <= {{WIDTH{1'b0}}, bAbs};
                                isDiv   <= 1'b0;
                                negLo   <= aNeg ^ bNeg;
                                negHi   <= 1'b0;
                                divZero <= 1'b0;
                                count   <= '0;
                                busyReg <= 1'b1;
                                state   <= CALC;
                            end
                            OP_DIV, OP_DIVU: begin
                                aMag    <= aAbs;
                                bMag    <= bAbs;
                                acc     <= {{WIDTH{1'b0}}, aAbs};
                                isDiv   <= 1'b1;
                                negLo   <= aNeg ^ bNeg;
                                negHi   <= aNeg;
                                divZero <= (bus.B == '0);
                                count   <= '0;
                                busyReg <= 1'b1;
                                state   <= CALC;
                            end
                            OP_MTHI: hiReg <= bus.A;
                            OP_MTLO: loReg <= bus.A;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (isDiv) begin
                        if (!divTrial[WIDTH])
                            acc <= {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                    end else begin
                        if (acc[0])
                            acc <= {mulSum, acc[WIDTH-1:1]};
                        else
                            acc <= {1'b0, acc[2*WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == LAST_STEP)
                        state <= FIX;
                end
                FIX: begin
                    // A zero divisor still burns the full latency but leaves HI/LO alone.
                    if (!isDiv) begin
                        hiReg <= prodFixed[2*WIDTH-1:WIDTH];
                        loReg <= prodFixed[WIDTH-1:0];
                    end else if (!divZero) begin
                        hiReg <= remFixed;
                        loReg <= quotFixed;
                    end
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busyReg;
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;
endmodule

// File: tb/tb_mdu.sv
// Randomized bench for mdu, checked against an arithmetic HI/LO reference model.
// Also covers the spec corner cases: divide by zero, overflow wrap, ignored starts, async reset.
module tb_mdu;
    logic clk;
    logic reset;

    int testCount;
    int failCount;

    logic [31:0] refHi;
    logic [31:0] refLo;

    mdu_if #(.WIDTH(32)) bus ();

    mdu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the architectural HI/LO.
    task automatic modelOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sProd;
        logic [63:0]        uProd;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (o)
            3'd0: begin
                sProd = 64'(sa) * 64'(sb);
                {refHi, refLo} = sProd;
            end
            3'd1: begin
                uProd = {32'd0, a} * {32'd0, b};
                {refHi, refLo} = uProd;
            end
            3'd2: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        refLo = 32'h8000_0000;
                        refHi = 32'd0;
                    end else begin
                        refLo = sa / sb;
                        refHi = sa % sb;
                    end
                end
            end
            3'd3: begin
                if (b != 32'd0) begin
                    refLo = a / b;
                    refHi = a % b;
                end
            end
            3'd4: refHi = a;
            3'd5: refLo = a;
            default: ;
        endcase
    endtask

    // Issues one op, optionally fires a second start while busy, then waits
    // (bounded) for idle and checks latency and HI/LO against the model.
    task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input int interfereAt,
                                 input logic [2:0] io, input logic [31:0] ia, input logic [31:0] ib);
        int cycles;
        int expCycles;
        logic [31:0] oldHi;
        logic [31:0] oldLo;
        oldHi = refHi;
        oldLo = refLo;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            if (cycles == 10) begin
                checkOutput({tag, "_holdhi"}, {32'd0, bus.hi}, {32'd0, oldHi});
                checkOutput({tag, "_holdlo"}, {32'd0, bus.lo}, {32'd0, oldLo});
            end
            if (cycles == interfereAt) begin
                bus.start = 1'b1;
                bus.op    = io;
                bus.A     = ia;
                bus.B     = ib;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        modelOp(o, a, b);
        expCycles = (o < 3'd4) ? 33 : 0;
        checkOutput({tag, "_busy"}, 64'(cycles), 64'(expCycles));
        checkOutput({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, refHi});
        checkOutput({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, refLo});
    endtask

    function automatic logic [31:0] randOperand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] rOp;
        testCount = 0;
        failCount = 0;
        refHi = 32'd0;
        refLo = 32'd0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.A = 32'd0;
        bus.B = 32'd0;

        #3;
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_hi", {32'd0, bus.hi}, 64'd0);
        checkOutput("reset_lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus("mult_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("mult_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        applyStimulus("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("multu_max_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        applyStimulus("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("div_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus("divu", 3'd3, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("divu_const", {bus.hi, bus.lo}, 64'h0000_0001_7FFF_FFFC);
        applyStimulus("mtlo", 3'd5, 32'h0000_1234, 32'd0, 0, 3'd0, 32'd0, 32'd0);
        applyStimulus("divu_zero", 3'd3, 32'd99, 32'd0, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("divu_zero_lo", {32'd0, bus.lo}, 64'h0000_1234);
        applyStimulus("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("div_ovf_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        applyStimulus("mthi", 3'd4, 32'hCAFE_F00D, 32'd0, 0, 3'd0, 32'd0, 32'd0);
        applyStimulus("op7", 3'd7, 32'h1111_1111, 32'h2222_2222, 0, 3'd0, 32'd0, 32'd0);
        applyStimulus("div_busy_start", 3'd2, 32'd1000, 32'hFFFF_FFF9, 10, 3'd0, 32'd5, 32'd6);
        applyStimulus("divu_busy_mtlo", 3'd3, 32'd12345, 32'd17, 20, 3'd5, 32'hDEAD_BEEF, 32'd0);

        // Async reset in the middle of a multiply: everything clears without a clock edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'd0;
        bus.A = 32'h1234_5678;
        bus.B = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("areset_busy", 64'(bus.busy), 64'd0);
        checkOutput("areset_hi", {32'd0, bus.hi}, 64'd0);
        checkOutput("areset_lo", {32'd0, bus.lo}, 64'd0);
        refHi = 32'd0;
        refLo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("after_reset", 3'd0, 32'hFFFF_FFFF, 32'd3, 0, 3'd0, 32'd0, 32'd0);

        for (int i = 0; i < 40; i++) begin
            rOp = 3'($urandom_range(0, 7));
            applyStimulus($sformatf("rand%0d_op%0d", i, rOp), rOp, randOperand(), randOperand(),
                          0, 3'd0, 32'd0, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
